aes_decrypt_engine: RTL

Iterative AES-128 decryption core, the inverse-direction partner of the team's AES encryption engine. It accepts a 128-bit key (anahtar) and a ciphertext block (sifre) on a valid/ready handshake, and returns the plaintext block (blok) with a one-cycle valid pulse. It performs one inverse round per clock. It expands the key schedule on-chip and optionally caches it, so repeated blocks under the same key skip expansion.

---
 rtl/aes_pkg.sv | 110 +++++++++++
 rtl/aes_decrypt_engine_if.sv | 21 ++
 rtl/aes_key_step.sv | 30 +++
 rtl/aes_decrypt_engine.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES helpers: S-box tables, round constants, GF(2^8) arithmetic
// and the state encoding of the decryption engine.
package aes_pkg;

   localparam int NB   = 4;
   localparam int NR   = 10;
   localparam int KEYW = 128;

   localparam logic [3:0] LAST_RK = 4'd10;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      KEYEXP = 2'b01,
      DEC    = 2'b10
   } dec_state_t;

   // Forward S-box, one table row per high nibble; low nibble picks the byte.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [127:0] row;
      logic [127:0] sh;
      case (a[7:4])
         4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
         4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
         4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
         4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
         4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
         4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
         4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
         4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
         4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
         4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
         4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
         4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
         4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
         4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
         4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
         4'hf: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
         default: row = 128'h0;
      endcase
      sh = row << {a[3:0], 3'b000};
      return sh[127:120];
   endfunction

   // Inverse S-box, same row/column layout as sbox.
   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      logic [127:0] row;
      logic [127:0] sh;
      case (a[7:4])
         4'h0: row = 128'h52096ad53036a538bf40a39e81f3d7fb;
         4'h1: row = 128'h7ce339829b2fff87348e4344c4dee9cb;
         4'h2: row = 128'h547b9432a6c2233dee4c950b42fac34e;
         4'h3: row = 128'h082ea16628d924b2765ba2496d8bd125;
         4'h4: row = 128'h72f8f66486689816d4a45ccc5d65b692;
         4'h5: row = 128'h6c704850fdedb9da5e154657a78d9d84;
         4'h6: row = 128'h90d8ab008cbcd30af7e45805b8b34506;
         4'h7: row = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
         4'h8: row = 128'h3a9111414f67dcea97f2cfcef0b4e673;
         4'h9: row = 128'h96ac7422e7ad3585e2f937e81c75df6e;
         4'ha: row = 128'h47f11a711d29c5896fb7620eaa18be1b;
         4'hb: row = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
         4'hc: row = 128'h1fdda8338807c731b11210592780ec5f;
         4'hd: row = 128'h60517fa919b54a0d2de57a9f93c99cef;
         4'he: row = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
         4'hf: row = 128'h172b047eba77d626e169146355210c7d;
         default: row = 128'h0;
      endcase
      sh = row << {a[3:0], 3'b000};
      return sh[127:120];
   endfunction

   // Round constant for key-schedule step 1..10.
   function automatic logic [7:0] rcon(input logic [3:0] i);
      case (i)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // Constant multiply for the InvMixColumns coefficients 09/0b/0d/0e.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] c);
      logic [7:0] x2;
      logic [7:0] x4;
      logic [7:0] x8;
      x2 = xtime(a);
      x4 = xtime(x2);
      x8 = xtime(x4);
      case (c)
         8'h09:   return x8 ^ a;
         8'h0b:   return x8 ^ x2 ^ a;
         8'h0d:   return x8 ^ x4 ^ a;
         8'h0e:   return x8 ^ x4 ^ x2;
         default: return 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/aes_decrypt_engine_if.sv
// Block handshake between a requester and the AES decryption engine.
interface aes_decrypt_engine_if;
   import aes_pkg::*;

   logic [KEYW-1:0] anahtar;
   logic [KEYW-1:0] sifre;
   logic            g_gecerli;
   logic            hazir;
   logic [KEYW-1:0] blok;
   logic            c_gecerli;

   modport master (
      output anahtar, sifre, g_gecerli,
      input  hazir, blok, c_gecerli
   );

   modport slave (
      input  anahtar, sifre, g_gecerli,
      output hazir, blok, c_gecerli
   );
endinterface

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step: rk[i] from rk[i-1] and round index i.
module aes_key_step
   import aes_pkg::*;
(
   input  logic [KEYW-1:0] prev_key,
   input  logic [3:0]      round,
   output logic [KEYW-1:0] next_key
);

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] rot, sub, tmp;
   logic [31:0] n0, n1, n2, n3;

   // RotWord/SubWord/Rcon on the last word, then the xor chain across words
   always_comb begin
      w0 = prev_key[127:96];
      w1 = prev_key[95:64];
      w2 = prev_key[63:32];
      w3 = prev_key[31:0];
      rot = {w3[23:0], w3[31:24]};
      sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
      tmp = sub ^ {rcon(round), 24'h000000};
      n0 = w0 ^ tmp;
      n1 = w1 ^ n0;
      n2 = w2 ^ n1;
      n3 = w3 ^ n2;
      next_key = {n0, n1, n2, n3};
   end

endmodule

// File: rtl/aes_decrypt_engine.sv
// Iterative AES-128 decryption: key expansion (optionally cached), then one
// inverse round per clock from round 9 down to 0.
module aes_decrypt_engine
   import aes_pkg::*;
#(
   parameter bit KEY_CACHE = 1'b1
)
(
   input  logic clk,
   input  logic rst,
   aes_decrypt_engine_if.slave bus
);

   dec_state_t      state;
   dec_state_t      next_state;
   logic [3:0]      round;
   logic [KEYW-1:0] rk [0:NR];
   logic [KEYW-1:0] ct_lat;
   logic [KEYW-1:0] data;
   logic [KEYW-1:0] cache_key;
   logic            cache_valid;
   logic [KEYW-1:0] blok_q;
   logic            pulse_q;

   logic            accept;
   logic            cache_hit;
   logic [KEYW-1:0] key_prev;
   logic [KEYW-1:0] key_next;
   logic [KEYW-1:0] rk_cur;
   logic [KEYW-1:0] ark;
   logic [KEYW-1:0] mixed;
   logic [KEYW-1:0] round_out;
   logic [7:0]      a0, a1, a2, a3;

   assign bus.hazir     = (state == IDLE) && !rst;
   assign bus.blok      = blok_q;
   assign bus.c_gecerli = pulse_q;

   // hazir already folds in rst, so a reset edge never accepts a block
   assign accept    = bus.g_gecerli && bus.hazir;
   assign cache_hit = KEY_CACHE && cache_valid && (bus.anahtar == cache_key);

   aes_key_step u_key_step (
      .prev_key (key_prev),
      .round    (round),
      .next_key (key_next)
   );

   // Select the previous round key feeding the schedule and the key for this round
   always_comb begin
      if ((round != 4'd0) && (round <= LAST_RK)) begin
         key_prev = rk[round - 4'd1];
      end else begin
         key_prev = rk[0];
      end
      if (round <= LAST_RK) begin
         rk_cur = rk[round];
      end else begin
         rk_cur = {KEYW{1'b0}};
      end
   end

   // Inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns unless last
   always_comb begin
      ark   = {KEYW{1'b0}};
      mixed = {KEYW{1'b0}};
      a0 = 8'h00;
      a1 = 8'h00;
      a2 = 8'h00;
      a3 = 8'h00;
      for (int c = 0; c < NB; c++) begin
         for (int r = 0; r < 4; r++) begin
            ark[127 - 8*(r + 4*c) -: 8] =
               inv_sbox(data[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8]) ^
               rk_cur[127 - 8*(r + 4*c) -: 8];
         end
      end
      for (int c = 0; c < NB; c++) begin
         a0 = ark[127 - 32*c -: 8];
         a1 = ark[119 - 32*c -: 8];
         a2 = ark[111 - 32*c -: 8];
         a3 = ark[103 - 32*c -: 8];
         mixed[127 - 32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
         mixed[119 - 32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
         mixed[111 - 32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
         mixed[103 - 32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
      end
      if (round == 4'd0) begin
         round_out = ark;
      end else begin
         round_out = mixed;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // FSM next-state logic
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (cache_hit) begin
                  next_state = DEC;
               end else begin
                  next_state = KEYEXP;
               end
            end else begin
               next_state = IDLE;
            end
         end
         KEYEXP: begin
            if (round == LAST_RK) begin
               next_state = DEC;
            end else begin
               next_state = KEYEXP;
            end
         end
         DEC: begin
            if (round == 4'd0) begin
               next_state = IDLE;
            end else begin
               next_state = DEC;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Round-key storage: rk0 on accept, rk1..rk10 during expansion (no reset needed)
   always_ff @(posedge clk) begin
      if (!rst) begin
         if ((state == IDLE) && accept) begin
            rk[0] <= bus.anahtar;
         end else if ((state == KEYEXP) && (round != 4'd0) && (round <= LAST_RK)) begin
            rk[round] <= key_next;
         end
      end
   end

   // Datapath: latch block, run rounds, publish result, maintain key cache
   always_ff @(posedge clk) begin
      if (rst) begin
         round       <= 4'd0;
         ct_lat      <= {KEYW{1'b0}};
         data        <= {KEYW{1'b0}};
         cache_key   <= {KEYW{1'b0}};
         cache_valid <= 1'b0;
         blok_q      <= {KEYW{1'b0}};
         pulse_q     <= 1'b0;
      end else begin
         pulse_q <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  ct_lat <= bus.sifre;
                  if (cache_hit) begin
                     data  <= bus.sifre ^ rk[NR];
                     round <= 4'd9;
                  end else begin
                     // the stored schedule is about to be overwritten
                     cache_valid <= 1'b0;
                     round       <= 4'd1;
                  end
               end
            end
            KEYEXP: begin
               if (round == LAST_RK) begin
                  data        <= ct_lat ^ key_next;
                  cache_key   <= rk[0];
                  cache_valid <= KEY_CACHE;
                  round       <= 4'd9;
               end else begin
                  round <= round + 4'd1;
               end
            end
            DEC: begin
               data <= round_out;
               if (round == 4'd0) begin
                  blok_q  <= round_out;
                  pulse_q <= 1'b1;
               end else begin
                  round <= round - 4'd1;
               end
            end
            default: begin
               round <= 4'd0;
            end
         endcase
      end
   end

endmodule
